// File: rtl/idu_multi_decode_pkg.sv
// rtl/idu_multi_decode_pkg.sv - shared decode types, opcode/ALU constants and helpers
package idu_multi_decode_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] alu_add  = 4'd0;
  localparam logic [3:0] alu_sub  = 4'd1;
  localparam logic [3:0] alu_sll  = 4'd2;
  localparam logic [3:0] alu_slt  = 4'd3;
  localparam logic [3:0] alu_sltu = 4'd4;
  localparam logic [3:0] alu_xor  = 4'd5;
  localparam logic [3:0] alu_srl  = 4'd6;
  localparam logic [3:0] alu_sra  = 4'd7;
  localparam logic [3:0] alu_or   = 4'd8;
  localparam logic [3:0] alu_and  = 4'd9;
  localparam logic [3:0] alu_mul  = 4'd10;
  localparam logic [3:0] alu_div  = 4'd11;

  typedef enum logic [3:0] {
    OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
    OP_STORE, OP_ALUI, OP_ALU, OP_FENCE, OP_SYSTEM
  } rv_op_e;

  typedef enum logic [1:0] {
    BR_TYPE_NONE, BR_TYPE_JAL, BR_TYPE_JALR, BR_TYPE_BRANCH
  } br_type_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic [3:0]         alu_op;
    rv_op_e             inst_op;
    logic [31:0]        imm;
    logic               ecall;
    logic               mret;
    logic               fence_i;
    logic               illegal;
  } rv_decode_pkt_t;

  // alt selects sub/sra for the funct3 codes that have an alternate form
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? alu_sub : alu_add;
      3'b001:  r = alu_sll;
      3'b010:  r = alu_slt;
      3'b011:  r = alu_sltu;
      3'b100:  r = alu_xor;
      3'b101:  r = alt ? alu_sra : alu_srl;
      3'b110:  r = alu_or;
      default: r = alu_and;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idu_multi_decode_if.sv
// rtl/idu_multi_decode_if.sv - fetch-side (slave) and dispatch-side (master) bundle interface
interface idu_multi_decode_if
  import idu_multi_decode_pkg::*;
#(
  parameter int DEC_WIDTH = 2
);

  logic                             slave_valid;
  logic                             slave_ready;
  logic [DEC_WIDTH*32-1:0]          inst;
  logic [RV_XLEN-1:0]               pc;
  logic [DEC_WIDTH-1:0]             lane_valid_in;
  logic [DEC_WIDTH-1:0]             pred_res;

  logic                             master_valid;
  logic                             master_ready;
  rv_decode_pkt_t [DEC_WIDTH-1:0]   dec_pkt;
  logic [DEC_WIDTH-1:0]             dec_lane_valid;
  logic                             br_commit;
  logic                             br_error;
  logic [RV_XLEN-1:0]               br_pc;
  logic [RV_XLEN-1:0]               br_npc;
  br_type_e                         br_type;

  modport slave (
    input  slave_valid, inst, pc, lane_valid_in, pred_res,
    output slave_ready
  );

  modport master (
    output master_valid, dec_pkt, dec_lane_valid,
    output br_commit, br_error, br_pc, br_npc, br_type,
    input  master_ready
  );

endinterface

// File: rtl/idu_multi_decode_rv_dec_lane.sv
// rtl/idu_multi_decode_rv_dec_lane.sv - combinational single RV32 instruction decoder
// DEC_MEXT_EN: enables decode of funct7=0000001 R-type as mul/div.
module rv_dec_lane
  import idu_multi_decode_pkg::*;
(
  input  logic [31:0]         inst_i,
  input  logic [RV_XLEN-1:0]  pc_i,
  input  logic                pred_res_i,
  output rv_decode_pkt_t      pkt_o,
  output logic                is_jal_o,
  output logic                jal_mispred_o,
  output logic [RV_XLEN-1:0]  imm_j_o
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  rv_op_e      op;
  logic [3:0]  alu;
  logic [31:0] imm;
  logic        ecall, mret, fence_i;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    legal   = 1'b0;
    op      = OP_NONE;
    alu     = alu_add;
    imm     = '0;
    ecall   = 1'b0;
    mret    = 1'b0;
    fence_i = 1'b0;
    case (opc)
      OPC_LUI:    begin legal = 1'b1; op = OP_LUI;   imm = imm_u; end
      OPC_AUIPC:  begin legal = 1'b1; op = OP_AUIPC; imm = imm_u; end
      OPC_JAL:    begin legal = 1'b1; op = OP_JAL;   imm = imm_j; end
      OPC_JALR:   begin legal = (f3 == 3'b000); op = OP_JALR; imm = imm_i; end
      OPC_BRANCH: begin legal = (f3 != 3'b010) && (f3 != 3'b011); op = OP_BRANCH; imm = imm_b; end
      OPC_LOAD:   begin legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111); op = OP_LOAD; imm = imm_i; end
      OPC_STORE:  begin legal = (f3 < 3'b011); op = OP_STORE; imm = imm_s; end
      OPC_OPIMM: begin
        op  = OP_ALUI;
        imm = imm_i;
        alu = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OPC_OP: begin
        op = OP_ALU;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          alu   = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101);
          alu   = alu_from_f3(f3, 1'b1);
        end
`ifdef DEC_MEXT_EN
        else if (f7 == 7'b0000001) begin
          legal = 1'b1;
          alu   = f3[2] ? alu_div : alu_mul;
        end
`else
`endif
      end
      OPC_MISC_MEM: begin
        op      = OP_FENCE;
        legal   = (f3 == 3'b000) || (f3 == 3'b001);
        fence_i = (f3 == 3'b001);
      end
      OPC_SYSTEM: begin
        op    = OP_SYSTEM;
        ecall = (inst_i == 32'h0000_0073);
        mret  = (inst_i == 32'h3020_0073);
        legal = ecall | mret;
      end
      default: legal = 1'b0;
    endcase
    // Illegal lanes carry only raw fields so nothing downstream acts on a half-decode.
    if (!legal) begin
      op      = OP_NONE;
      alu     = alu_add;
      imm     = '0;
      ecall   = 1'b0;
      mret    = 1'b0;
      fence_i = 1'b0;
    end
  end

  always_comb begin
    pkt_o         = '0;
    pkt_o.pc      = pc_i;
    pkt_o.rs1     = inst_i[19:15];
    pkt_o.rs2     = inst_i[24:20];
    pkt_o.rd      = inst_i[11:7];
    pkt_o.funct3  = f3;
    pkt_o.alu_op  = alu;
    pkt_o.inst_op = op;
    pkt_o.imm     = imm;
    pkt_o.ecall   = ecall;
    pkt_o.mret    = mret;
    pkt_o.fence_i = fence_i;
    pkt_o.illegal = ~legal;
  end

  assign is_jal_o      = (opc == OPC_JAL);
  assign jal_mispred_o = is_jal_o & ~pred_res_i;
  assign imm_j_o       = imm_j;

endmodule

// File: rtl/idu_multi_decode.sv
// rtl/idu_multi_decode.sv - DEC_WIDTH-lane decode stage with skid buffer, JAL squash and redirect
// DEC_MEXT_EN: enables M-extension mul/div decode in every lane.
module idu_multi_decode
  import idu_multi_decode_pkg::*;
#(
  parameter int DEC_WIDTH = 2,
  parameter int XLEN      = RV_XLEN
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inst_kill_i,
  idu_multi_decode_if.slave     fetch,
  idu_multi_decode_if.master    disp
);

  typedef struct packed {
    rv_decode_pkt_t [DEC_WIDTH-1:0] pkt;
    logic [DEC_WIDTH-1:0]           lv;
  } entry_t;

  rv_decode_pkt_t [DEC_WIDTH-1:0] lane_pkt;
  logic [DEC_WIDTH-1:0]           lane_jal;
  logic [DEC_WIDTH-1:0]           lane_misp;
  logic [XLEN-1:0]                lane_immj [DEC_WIDTH];

  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_lane
    rv_dec_lane u_lane (
      .inst_i        (fetch.inst[32*i +: 32]),
      .pc_i          (fetch.pc + XLEN'(4 * i)),
      .pred_res_i    (fetch.pred_res[i]),
      .pkt_o         (lane_pkt[i]),
      .is_jal_o      (lane_jal[i]),
      .jal_mispred_o (lane_misp[i]),
      .imm_j_o       (lane_immj[i])
    );
  end

  logic [DEC_WIDTH-1:0] lv_sq;
  logic                 jal_hit, jal_err;
  logic [XLEN-1:0]      jal_pc, jal_npc;

  // Lanes younger than an unpredicted JAL are on the wrong path.
  always_comb begin
    lv_sq   = fetch.lane_valid_in;
    jal_hit = 1'b0;
    jal_err = 1'b0;
    jal_pc  = '0;
    jal_npc = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      if (jal_hit && jal_err) begin
        lv_sq[i] = 1'b0;
      end else if (!jal_hit && fetch.lane_valid_in[i] && lane_jal[i]) begin
        jal_hit = 1'b1;
        jal_err = lane_misp[i];
        jal_pc  = lane_pkt[i].pc;
        jal_npc = lane_pkt[i].pc + lane_immj[i];
      end
    end
  end

  entry_t          out_q, out_d, skid_q, skid_d, new_e;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic            slave_ready_q, slave_ready_d;
  logic            br_commit_q, br_commit_d, br_error_q, br_error_d;
  logic [XLEN-1:0] br_pc_q, br_pc_d, br_npc_q, br_npc_d;
  br_type_e        br_type_q, br_type_d;
  logic            accept;

  assign accept    = fetch.slave_valid & slave_ready_q;
  assign new_e.pkt = lane_pkt;
  assign new_e.lv  = lv_sq;

  // slave_ready is low whenever SKID holds data, so accept never coincides with a SKID drain.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    br_pc_d      = br_pc_q;
    br_npc_d     = br_npc_q;
    br_commit_d  = 1'b0;
    br_error_d   = 1'b0;
    if (inst_kill_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (!out_valid_q || disp.master_ready) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          out_d       = accept ? new_e : out_q;
          out_valid_d = accept;
        end
      end else if (accept) begin
        skid_d       = new_e;
        skid_valid_d = 1'b1;
      end
      br_commit_d = accept & jal_hit;
      br_error_d  = accept & jal_hit & jal_err;
      if (accept && jal_hit) begin
        br_pc_d  = jal_pc;
        br_npc_d = jal_npc;
      end
    end
    slave_ready_d = ~skid_valid_d;
    br_type_d     = br_commit_d ? BR_TYPE_JAL : BR_TYPE_NONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      slave_ready_q <= 1'b1;
      br_commit_q   <= 1'b0;
      br_error_q    <= 1'b0;
      br_pc_q       <= '0;
      br_npc_q      <= '0;
      br_type_q     <= BR_TYPE_NONE;
    end else begin
      out_q         <= out_d;
      skid_q        <= skid_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
      slave_ready_q <= slave_ready_d;
      br_commit_q   <= br_commit_d;
      br_error_q    <= br_error_d;
      br_pc_q       <= br_pc_d;
      br_npc_q      <= br_npc_d;
      br_type_q     <= br_type_d;
    end
  end

  assign fetch.slave_ready    = slave_ready_q;
  assign disp.master_valid    = out_valid_q;
  assign disp.dec_pkt         = out_q.pkt;
  assign disp.dec_lane_valid  = out_q.lv & {DEC_WIDTH{out_valid_q}};
  assign disp.br_commit       = br_commit_q;
  assign disp.br_error        = br_error_q;
  assign disp.br_pc           = br_pc_q;
  assign disp.br_npc          = br_npc_q;
  assign disp.br_type         = br_type_q;

endmodule

// File: tb/tb_idu_multi_decode.sv
// tb/tb_idu_multi_decode.sv - randomized and directed bench against a queue-based reference model
module tb_idu_multi_decode;
  import idu_multi_decode_pkg::*;

  localparam int DW = 2;

  typedef struct {
    rv_decode_pkt_t pkt [DW];
    logic [DW-1:0]  lv;
  } bundle_t;

  logic clk = 1'b0;
  logic rst;
  logic kill;
  int   n_tests = 0;
  int   n_fail  = 0;

  bundle_t     exp_q[$];
  logic        e_commit = 1'b0;
  logic        e_error  = 1'b0;
  logic [31:0] e_pc     = '0;
  logic [31:0] e_npc    = '0;

  always #5 clk = ~clk;

  idu_multi_decode_if #(.DEC_WIDTH(DW)) bus ();

  idu_multi_decode #(.DEC_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .inst_kill_i (kill),
    .fetch       (bus),
    .disp        (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'd1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  function automatic rv_decode_pkt_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    rv_decode_pkt_t p;
    logic [3:0] tab [8];
    int  opc, f3, f7;
    bit  ok;
    tab = '{alu_add, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_or, alu_and};
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    p = '0;
    p.pc = pc; p.rs1 = w[19:15]; p.rs2 = w[24:20]; p.rd = w[11:7]; p.funct3 = w[14:12];
    p.alu_op = alu_add;
    ok = 0;
    case (opc)
      'h37: begin ok = 1; p.inst_op = OP_LUI;   p.imm = {w[31:12], 12'h000}; end
      'h17: begin ok = 1; p.inst_op = OP_AUIPC; p.imm = {w[31:12], 12'h000}; end
      'h6F: begin ok = 1; p.inst_op = OP_JAL;
                  p.imm = sext({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); end
      'h67: begin ok = (f3 == 0); p.inst_op = OP_JALR; p.imm = sext({20'b0, w[31:20]}, 12); end
      'h63: begin ok = !(f3 inside {2, 3}); p.inst_op = OP_BRANCH;
                  p.imm = sext({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); end
      'h03: begin ok = (f3 inside {0, 1, 2, 4, 5}); p.inst_op = OP_LOAD; p.imm = sext({20'b0, w[31:20]}, 12); end
      'h23: begin ok = (f3 < 3); p.inst_op = OP_STORE; p.imm = sext({20'b0, w[31:25], w[11:7]}, 12); end
      'h13: begin
        p.inst_op = OP_ALUI;
        p.imm     = sext({20'b0, w[31:20]}, 12);
        p.alu_op  = (f3 == 5 && f7 == 'h20) ? alu_sra : tab[f3];
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1;
      end
      'h33: begin
        p.inst_op = OP_ALU;
        if (f7 == 0) begin ok = 1; p.alu_op = tab[f3]; end
        else if (f7 == 'h20 && f3 == 0) begin ok = 1; p.alu_op = alu_sub; end
        else if (f7 == 'h20 && f3 == 5) begin ok = 1; p.alu_op = alu_sra; end
`ifdef DEC_MEXT_EN
        else if (f7 == 1) begin ok = 1; p.alu_op = (f3 >= 4) ? alu_div : alu_mul; end
`endif
      end
      'h0F: begin ok = (f3 <= 1); p.inst_op = OP_FENCE; p.fence_i = (f3 == 1); end
      'h73: begin
        p.inst_op = OP_SYSTEM;
        p.ecall = (w == 32'h0000_0073);
        p.mret  = (w == 32'h3020_0073);
        ok = p.ecall || p.mret;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      p.inst_op = OP_NONE; p.alu_op = alu_add; p.imm = '0;
      p.ecall = 0; p.mret = 0; p.fence_i = 0;
    end
    p.illegal = !ok;
    return p;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [11];
    logic [6:0]  f7s [4];
    logic [31:0] w;
    int          k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    f7s  = '{7'h00, 7'h20, 7'h01, 7'h7F};
    w = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) w[6:0] = opcs[k];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if (w[6:0] == 7'h73) begin
      k = $urandom_range(0, 2);
      if (k == 0) w = 32'h0000_0073;
      else if (k == 1) w = 32'h3020_0073;
    end
    return w;
  endfunction

  task automatic check_outputs();
    check("master_valid", bus.master_valid, exp_q.size() > 0);
    check("slave_ready", bus.slave_ready, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      for (int i = 0; i < DW; i++) check($sformatf("pkt%0d", i), bus.dec_pkt[i], exp_q[0].pkt[i]);
      check("lane_valid", bus.dec_lane_valid, exp_q[0].lv);
    end else begin
      check("lane_valid_idle", bus.dec_lane_valid, 0);
    end
    check("br_commit", bus.br_commit, e_commit);
    check("br_error", bus.br_error, e_error);
    check("br_type", bus.br_type, e_commit ? BR_TYPE_JAL : BR_TYPE_NONE);
    if (e_commit) begin
      check("br_pc", bus.br_pc, e_pc);
      check("br_npc", bus.br_npc, e_npc);
    end
  endtask

  task automatic step(input logic sv, input logic [DW*32-1:0] ins, input logic [31:0] pc,
                      input logic [DW-1:0] lv, input logic [DW-1:0] pr,
                      input logic mr, input logic kl);
    bundle_t     b;
    bit          acc, pop, hit, err;
    logic [31:0] hpc, hnpc;
    bus.slave_valid   = sv;
    bus.inst          = ins;
    bus.pc            = pc;
    bus.lane_valid_in = lv;
    bus.pred_res      = pr;
    bus.master_ready  = mr;
    kill              = kl;
    acc = sv && (exp_q.size() < 2);
    pop = mr && (exp_q.size() > 0);
    hit = 0; err = 0; hpc = '0; hnpc = '0;
    b.lv = lv;
    for (int i = 0; i < DW; i++) begin
      b.pkt[i] = ref_decode(ins[32*i +: 32], pc + 32'(4 * i));
      if (hit && err) b.lv[i] = 1'b0;
      else if (!hit && lv[i] && b.pkt[i].inst_op == OP_JAL) begin
        hit = 1; err = !pr[i]; hpc = b.pkt[i].pc; hnpc = b.pkt[i].pc + b.pkt[i].imm;
      end
    end
    @(posedge clk);
    if (kl) begin
      exp_q.delete();
      e_commit = 0;
      e_error  = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(b);
      e_commit = acc && hit;
      e_error  = acc && hit && err;
      if (acc && hit) begin e_pc = hpc; e_npc = hnpc; end
    end
    @(negedge clk);
    check_outputs();
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL16 = 32'h0100_006F;

  initial begin
    rst = 1'b1;
    kill = 1'b0;
    bus.slave_valid = 0; bus.inst = '0; bus.pc = '0; bus.lane_valid_in = '0;
    bus.pred_res = '0; bus.master_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();
    check("rst_pkt0", bus.dec_pkt[0], 128'd0);

    // JAL squash and redirect
    step(1, {NOP, JAL16}, 32'h8000_0000, 2'b11, 2'b00, 1, 0);
    check("jal_commit", bus.br_commit, 1);
    check("jal_error", bus.br_error, 1);
    check("jal_npc", bus.br_npc, 32'h8000_0010);
    check("jal_lv", bus.dec_lane_valid, 2'b01);
    step(0, '0, '0, '0, '0, 1, 0);
    check("jal_no_hold", bus.br_commit, 0);

    // M-extension encoding
    step(1, {NOP, 32'h02B5_0533}, 32'h0000_1000, 2'b11, 2'b00, 1, 0);
`ifdef DEC_MEXT_EN
    check("mext_alu", bus.dec_pkt[0].alu_op, alu_mul);
    check("mext_illegal", bus.dec_pkt[0].illegal, 0);
`else
    check("mext_op", bus.dec_pkt[0].inst_op, OP_NONE);
    check("mext_illegal", bus.dec_pkt[0].illegal, 1);
`endif
    step(0, '0, '0, '0, '0, 1, 0);

    // immediate sign extension and PC wrap
    step(1, {32'hFFF0_0093, NOP}, 32'hFFFF_FFFC, 2'b11, 2'b00, 1, 0);
    check("wrap_imm", bus.dec_pkt[1].imm, 32'hFFFF_FFFF);
    check("wrap_pc", bus.dec_pkt[1].pc, 32'h0000_0000);
    step(0, '0, '0, '0, '0, 1, 0);

    // back-pressure: three offered, two held, drained in order
    step(1, {NOP, NOP}, 32'h100, 2'b11, 2'b00, 0, 0);
    step(1, {NOP, NOP}, 32'h200, 2'b10, 2'b00, 0, 0);
    check("bp_ready_low", bus.slave_ready, 0);
    step(1, {NOP, NOP}, 32'h300, 2'b01, 2'b00, 0, 0);
    check("bp_held_pc", bus.dec_pkt[0].pc, 32'h100);
    repeat (3) step(0, '0, '0, '0, '0, 1, 0);

    // empty lane mask still forwarded
    step(1, {NOP, NOP}, 32'h400, 2'b00, 2'b00, 1, 0);
    check("empty_mv", bus.master_valid, 1);
    step(0, '0, '0, '0, '0, 1, 0);

    // kill with skid full, then kill during an accepting cycle
    step(1, {NOP, NOP}, 32'h500, 2'b11, 2'b00, 0, 0);
    step(1, {NOP, NOP}, 32'h600, 2'b11, 2'b00, 0, 0);
    step(1, {NOP, JAL16}, 32'h700, 2'b11, 2'b00, 0, 1);
    check("kill_mv", bus.master_valid, 0);
    check("kill_ready", bus.slave_ready, 1);
    step(1, {NOP, JAL16}, 32'h800, 2'b11, 2'b00, 0, 1);
    check("kill_acc_br", bus.br_commit, 0);
    check("kill_acc_mv", bus.master_valid, 0);

    // reset while stalled
    step(1, {NOP, NOP}, 32'h900, 2'b11, 2'b00, 0, 0);
    rst = 1'b1;
    exp_q.delete();
    e_commit = 0;
    e_error  = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_stall_mv", bus.master_valid, 0);
    check("rst_stall_ready", bus.slave_ready, 1);
    check("rst_stall_op", bus.dec_pkt[0].inst_op, OP_NONE);

    for (int n = 0; n < 1500; n++) begin
      logic [DW*32-1:0] ins;
      for (int l = 0; l < DW; l++) ins[32*l +: 32] = rand_inst();
      step($urandom_range(0, 3) != 0, ins, $urandom & 32'hFFFF_FFFC,
           DW'($urandom), DW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
